ibex_fpu_issue_ctrl: RTL
========================

// Module: ibex_fpu_issue_ctrl
// PURPOSE
//  Sequences one FP instruction at a time through the combinational FPU datapath (ibex_FPU).
//  - Front side: accepts requests from decode with a valid/ready handshake.
//  - Datapath side: holds op, operands and rounding mode stable for the op's latency.
//  - Back side: captures the result and presents it to the register-file writeback arbiter with valid/ready.
//  - Accumulates sticky RISC-V fflags from the datapath status.
// PARAMETERS
//  LAT_BASE  1  cycles for add/sub/mul/cmp/min/max/sgnj/move/cvt/class
//  LAT_MAC   2  cycles for MADD/MSUB/NMADD/NMSUB
//  LAT_DIV   4  cycles for DIV
//  LAT_SQRT  4  cycles for SQRT
//  All latencies must be >= 1. CNT_W = $clog2(max latency + 1), derived localparam.
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   synchronous, active-high reset
//  flush_i         in   1   drop the in-flight op (sync)
//  req_valid_i     in   1   request valid
//  req_ready_o     out  1   request accepted when valid&ready
//  req_op_i        in   fpu_op_e  operation
//  req_rm_i        in   3   rounding mode (already resolved, not DYN)
//  req_rs1_i/req_rs2_i/req_rs3_i  in  32 each  FP operands
//  req_rs1_int_i   in   32  integer operand
//  req_rd_i        in   5   destination register
//  fpu_op_o        out  fpu_op_e  to datapath; FPU_NOP unless in EXEC
//  fpu_rm_o        out  3   to datapath
//  fpu_rs1_o/fpu_rs2_o/fpu_rs3_o/fpu_rs1_int_o  out  32 each  to datapath, registered
//  fpu_fp_wdata_i/fpu_int_wdata_i  in  32 each  datapath results
//  fpu_status_i    in   8   status of the active unit, DW bit order
//  wb_valid_o      out  1   writeback valid
//  wb_ready_i      in   1   arbiter accepts
//  wb_is_int_o     out  1   1 = integer RF, 0 = FP RF
//  wb_addr_o       out  5   destination register
//  wb_data_o       out  32  result
//  fflags_o        out  5   sticky {NV,DZ,OF,UF,NX}
//  fflags_clr_i    in   1   clear fflags (CSR write)
//  busy_o          out  1   state != IDLE
// BEHAVIOUR
//  Reset values:
//  - FSM = IDLE; all outputs 0, except fpu_op_o = FPU_NOP and req_ready_o = 1.
//  FSM states: IDLE, EXEC, WB.
//  - IDLE: req_ready_o = 1.
//    - On accept of FPU_NOP: stay in IDLE; no writeback.
//    - On accept of any other op: latch op, rm, operands and rd; cnt = LAT(op) - 1; go to EXEC.
//  - EXEC: fpu_op_o = latched op; operand outputs frozen.
//    - If cnt != 0: cnt decrements.
//    - If cnt == 0: capture wb data, wb_is_int and fflags_new; go to WB.
//    - wb_data source: fpu_int_wdata_i if the op is int-dest, else fpu_fp_wdata_i.
//    - Destination is decided by the op, never by datapath write enables.
//  - WB: wb_valid_o = 1; data, addr and is_int held stable until wb_ready_i.
//    - On the handshake: fflags update; go to IDLE.
//    - req_ready_o = wb_ready_i in WB. A request accepted on the handshake cycle is latched and goes straight to EXEC (back-to-back).
//  Latency: accept at cycle t -> wb_valid_o at t + LAT(op) + 1.
//  Throughput: one op per LAT + 1 cycles with back-to-back issue.
//  fflags mapping from status s:
//  - NV = s[2], DZ = s[7], OF = s[4], UF = s[3], NX = s[5].
//  - Move, sgnj and class ops contribute 0.
//  fflags update rule:
//  - fflags_clr_i alone -> 0.
//  - Handshake alone -> fflags_o | new.
//  - Both in the same cycle -> new.
//  flush_i (any state):
//  - Next state IDLE; no wb_valid_o the following cycle; fflags unchanged.
//  - req_ready_o = 0 while flush_i = 1.
//  rst_i mid-op: same as flush, and fflags are cleared.
//  rst_i and flush_i together: rst wins.
//  Unknown or illegal op: treated as FPU_NOP.
// STRUCTURE
//  ibex_fp_pkg additions:
//  - fpu_state_e {IDLE, EXEC, WB}
//  - function fpu_dst_is_int(fpu_op_e): true for FLOAT2INT, FLOAT2INT_U, MOVE_FLOAT2INT, CMP_*, FCLASS
//  - function fpu_latency_class(fpu_op_e)
//  - localparam indices of the DW status bits
//  No sub-module: the FSM, latency counter and operand/result registers live in one file. Instantiated beside ibex_FPU.
// TESTING
//  1) ADD rs1=0x3F800000, rs2=0x40000000, rm=RNE
//     -> wb_valid at t+2; data=0x40400000, is_int=0; fflags=0.
//  2) DIV rs1=0x3F800000, rs2=0x00000000
//     -> wb_valid at t+5; data=0x7F800000; fflags=5'b01000.
//  3) FLOAT2INT rs1=0x40490FDB (3.14159), rm=RTZ
//     -> wb_is_int=1, data=0x00000003, NX set.
//  4) Backpressure: hold wb_ready_i=0 for 3 cycles
//     -> wb_* stable, req_ready_o=0; ready then issues back-to-back ADD, its wb_valid 2 cycles later.
//  5) flush_i in 2nd EXEC cycle of SQRT
//     -> IDLE next cycle; no wb_valid; fflags unchanged.
//  6) rst_i during EXEC with fflags=0x1F -> all outputs at reset values, fflags=0;
//     fflags_clr_i on a handshake with NX -> fflags=5'b00001.

Source files
------------

// File: rtl/ibex_fpu_issue_ctrl_pkg.sv
// Shared types and helpers for the FP issue controller: op encoding, FSM states,
// latency classes, destination selection and status-to-fflags mapping.
package ibex_fpu_issue_ctrl_pkg;

  typedef enum logic [4:0] {
    FPU_NOP            = 5'd0,
    FPU_ADD            = 5'd1,
    FPU_SUB            = 5'd2,
    FPU_MUL            = 5'd3,
    FPU_DIV            = 5'd4,
    FPU_SQRT           = 5'd5,
    FPU_MADD           = 5'd6,
    FPU_MSUB           = 5'd7,
    FPU_NMADD          = 5'd8,
    FPU_NMSUB          = 5'd9,
    FPU_MIN            = 5'd10,
    FPU_MAX            = 5'd11,
    FPU_SGNJ           = 5'd12,
    FPU_SGNJN          = 5'd13,
    FPU_SGNJX          = 5'd14,
    FPU_CMP_EQ         = 5'd15,
    FPU_CMP_LT         = 5'd16,
    FPU_CMP_LE         = 5'd17,
    FPU_FLOAT2INT      = 5'd18,
    FPU_FLOAT2INT_U    = 5'd19,
    FPU_INT2FLOAT      = 5'd20,
    FPU_INT2FLOAT_U    = 5'd21,
    FPU_MOVE_FLOAT2INT = 5'd22,
    FPU_MOVE_INT2FLOAT = 5'd23,
    FPU_FCLASS         = 5'd24
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } fpu_state_e;

  typedef enum logic [2:0] {
    LAT_NONE = 3'd0,
    LAT_BASE_C = 3'd1,
    LAT_MAC_C = 3'd2,
    LAT_DIV_C = 3'd3,
    LAT_SQRT_C = 3'd4
  } fpu_lat_class_e;

  // Bit positions of the individual exceptions inside the datapath status byte
  localparam int unsigned STATUS_NV_BIT = 2;
  localparam int unsigned STATUS_UF_BIT = 3;
  localparam int unsigned STATUS_OF_BIT = 4;
  localparam int unsigned STATUS_NX_BIT = 5;
  localparam int unsigned STATUS_DZ_BIT = 7;

  // LAT_NONE marks FPU_NOP and every undefined encoding; both are dropped at issue.
  function automatic fpu_lat_class_e fpu_latency_class(fpu_op_e op);
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_MIN, FPU_MAX,
      FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE,
      FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_INT2FLOAT, FPU_INT2FLOAT_U,
      FPU_MOVE_FLOAT2INT, FPU_MOVE_INT2FLOAT, FPU_FCLASS: return LAT_BASE_C;
      FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB:            return LAT_MAC_C;
      FPU_DIV:                                             return LAT_DIV_C;
      FPU_SQRT:                                            return LAT_SQRT_C;
      default:                                             return LAT_NONE;
    endcase
  endfunction

  function automatic logic fpu_dst_is_int(fpu_op_e op);
    return op inside {FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_MOVE_FLOAT2INT,
                      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_FCLASS};
  endfunction

  // Bit moves cannot raise exceptions, so their status is ignored.
  function automatic logic [4:0] fpu_flags_from_status(fpu_op_e op, logic [7:0] s);
    if (op inside {FPU_SGNJ, FPU_SGNJN, FPU_SGNJX, FPU_MOVE_FLOAT2INT,
                   FPU_MOVE_INT2FLOAT, FPU_FCLASS}) begin
      return 5'b00000;
    end
    return {s[STATUS_NV_BIT], s[STATUS_DZ_BIT], s[STATUS_OF_BIT],
            s[STATUS_UF_BIT], s[STATUS_NX_BIT]};
  endfunction

endpackage

// File: rtl/ibex_fpu_issue_ctrl.sv
// Issue controller that sequences one FP op at a time through the combinational
// FPU datapath, holds its result for writeback and accumulates sticky fflags.
module ibex_fpu_issue_ctrl
  import ibex_fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT_BASE = 1,
  parameter int unsigned LAT_MAC  = 2,
  parameter int unsigned LAT_DIV  = 4,
  parameter int unsigned LAT_SQRT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fpu_op_e     req_op_i,
  input  logic [2:0]  req_rm_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [31:0] req_rs3_i,
  input  logic [31:0] req_rs1_int_i,
  input  logic [4:0]  req_rd_i,
  output fpu_op_e     fpu_op_o,
  output logic [2:0]  fpu_rm_o,
  output logic [31:0] fpu_rs1_o,
  output logic [31:0] fpu_rs2_o,
  output logic [31:0] fpu_rs3_o,
  output logic [31:0] fpu_rs1_int_o,
  input  logic [31:0] fpu_fp_wdata_i,
  input  logic [31:0] fpu_int_wdata_i,
  input  logic [7:0]  fpu_status_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic        wb_is_int_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i,
  output logic        busy_o,
  output fpu_state_e  state_o
);

  localparam int unsigned LAT_MAX_A = (LAT_BASE > LAT_MAC) ? LAT_BASE : LAT_MAC;
  localparam int unsigned LAT_MAX_B = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int unsigned LAT_MAX   = (LAT_MAX_A > LAT_MAX_B) ? LAT_MAX_A : LAT_MAX_B;
  localparam int unsigned CNT_W     = $clog2(LAT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LAT_BASE - 1);
  localparam logic [CNT_W-1:0] CNT_MAC  = CNT_W'(LAT_MAC - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SQRT = CNT_W'(LAT_SQRT - 1);

  fpu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  fpu_op_e          op_q;
  logic [2:0]       rm_q;
  logic [31:0]      rs1_q, rs2_q, rs3_q, rs1_int_q;
  logic [4:0]       rd_q;
  logic             wb_is_int_q;
  logic [31:0]      wb_data_q;
  logic [4:0]       flags_new_q;
  logic [4:0]       fflags_q;

  fpu_lat_class_e   req_class;
  logic             req_is_op;
  logic             accept;
  logic             wb_hs;
  logic [CNT_W-1:0] req_cnt;

  /*
   * Handshakes: a transfer happens on a rising edge where valid and ready are
   * both high; valid never depends on ready. flush_i masks both req_ready_o and
   * wb_valid_o in its cycle, so a flushed op can neither issue nor retire.
   */
  assign req_class   = fpu_latency_class(req_op_i);
  assign req_is_op   = (req_class != LAT_NONE);
  assign wb_valid_o  = (state_q == ST_WB) && !flush_i;
  assign wb_hs       = wb_valid_o && wb_ready_i;
  assign req_ready_o = !flush_i && ((state_q == ST_IDLE) || ((state_q == ST_WB) && wb_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    req_cnt = CNT_BASE;
    case (req_class)
      LAT_MAC_C:  req_cnt = CNT_MAC;
      LAT_DIV_C:  req_cnt = CNT_DIV;
      LAT_SQRT_C: req_cnt = CNT_SQRT;
      default:    req_cnt = CNT_BASE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= FPU_NOP;
      rm_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      rs1_int_q   <= '0;
      rd_q        <= '0;
      wb_is_int_q <= 1'b0;
      wb_data_q   <= '0;
      flags_new_q <= '0;
      fflags_q    <= '0;
    end else begin
      // A clear together with a retiring op leaves only that op's flags
      if (fflags_clr_i) begin
        fflags_q <= wb_hs ? flags_new_q : 5'b00000;
      end else if (wb_hs) begin
        fflags_q <= fflags_q | flags_new_q;
      end

      if (accept && req_is_op) begin
        op_q      <= req_op_i;
        rm_q      <= req_rm_i;
        rs1_q     <= req_rs1_i;
        rs2_q     <= req_rs2_i;
        rs3_q     <= req_rs3_i;
        rs1_int_q <= req_rs1_int_i;
        rd_q      <= req_rd_i;
        cnt_q     <= req_cnt;
      end

      if (flush_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept && req_is_op) state_q <= ST_EXEC;
          end
          ST_EXEC: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              wb_is_int_q <= fpu_dst_is_int(op_q);
              wb_data_q   <= fpu_dst_is_int(op_q) ? fpu_int_wdata_i : fpu_fp_wdata_i;
              flags_new_q <= fpu_flags_from_status(op_q, fpu_status_i);
              state_q     <= ST_WB;
            end
          end
          ST_WB: begin
            if (wb_hs) state_q <= (accept && req_is_op) ? ST_EXEC : ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign fpu_op_o      = (state_q == ST_EXEC) ? op_q : FPU_NOP;
  assign fpu_rm_o      = rm_q;
  assign fpu_rs1_o     = rs1_q;
  assign fpu_rs2_o     = rs2_q;
  assign fpu_rs3_o     = rs3_q;
  assign fpu_rs1_int_o = rs1_int_q;
  assign wb_is_int_o   = wb_is_int_q;
  assign wb_addr_o     = rd_q;
  assign wb_data_o     = wb_data_q;
  assign fflags_o      = fflags_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign state_o       = state_q;

endmodule
